// File: rtl/uart_tx_engine_pkg.sv
// rtl/uart_tx_engine_pkg.sv - shared state encodings, code constants and OVS check for the UART transmit engine
package uart_tx_engine_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START_DLY = 4'd1,
        ST_START     = 4'd2,
        ST_DATA      = 4'd3,
        ST_PARITY    = 4'd4,
        ST_STOP      = 4'd5,
        ST_GUARD     = 4'd6,
        ST_STOP_DLY  = 4'd7,
        ST_BREAK     = 4'd8,
        ST_BRK_MARK  = 4'd9
    } tx_state_e;

    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;
    localparam logic [1:0] STOP_2   = 2'd2;
    localparam logic [1:0] STOP_2B  = 2'd3;

    localparam logic [1:0] PAR_ODD   = 2'd0;
    localparam logic [1:0] PAR_EVEN  = 2'd1;
    localparam logic [1:0] PAR_SPACE = 2'd2;
    localparam logic [1:0] PAR_MARK  = 2'd3;

    function automatic bit ovs_legal(input int ovs);
        return (ovs == 4) || (ovs == 8) || (ovs == 16);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - oversample tick counter with full-bit and half-bit terminal pulses
module uart_bit_timer
    import uart_tx_engine_pkg::*;
#(
    parameter int OVS = 16
)
(
    input  logic Clk,
    input  logic Rst,
    input  logic i_ce,
    input  logic i_clr,
    output logic o_full,
    output logic o_half
);

    // An unsupported ratio falls back to 16 rather than producing odd bit lengths.
    localparam int OVS_E = ovs_legal(OVS) ? OVS : 16;
    localparam int CW    = $clog2(OVS_E);
    localparam logic [CW-1:0] LAST = CW'(OVS_E - 1);
    localparam logic [CW-1:0] HALF = CW'(OVS_E / 2 - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ce) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_full = i_ce && (r_cnt == LAST);
    assign o_half = i_ce && (r_cnt == HALF);

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit engine: framing, parity, stop/guard timing, flow control and break
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int OVS  = 16,
    parameter int MAXW = 9,
    parameter int GW   = 8
)
(
    input  logic            Clk,
    input  logic            Rst,
    input  logic            CE_Ovs,
    input  logic [3:0]      Len,
    input  logic [1:0]      NumStop,
    input  logic            ParEn,
    input  logic [1:0]      Par,
    input  logic [GW-1:0]   Guard,
    input  logic            Brk,
    input  logic            TF_EF,
    input  logic [MAXW-1:0] THR,
    output logic            TF_RE,
    input  logic            CTSi,
    output logic            TxD,
    output logic            TxIdle,
    output logic            TxStart,
    output logic            TxShift,
    output logic            TxStop,
    output logic            TxBrk,
    output logic            TxDone
);

    localparam int CW = (GW > 4) ? GW : 4;

    tx_state_e       r_state;
    tx_state_e       w_next;
    tx_state_e       w_boundary;
    logic [MAXW-1:0] r_tsr;
    logic [3:0]      r_len;
    logic [1:0]      r_nstop;
    logic            r_paren;
    logic [1:0]      r_par;
    logic [GW-1:0]   r_guard;
    logic [CW-1:0]   r_bitcnt;
    logic            r_txd;
    logic            r_tf_re;
    logic            r_done;

    logic            w_full;
    logic            w_half;
    logic            w_tmr_clr;
    logic            w_load;
    logic            w_brk_enter;
    logic            w_stop_done;
    logic            w_txd;
    logic            w_data_bit;
    logic            w_parity;
    logic [3:0]      w_len_eff;
    logic [CW-1:0]   w_brk_min;
    logic [MAXW-1:0] w_mask;

    assign w_len_eff = (Len < 4'd5 || Len > 4'(MAXW)) ? 4'(MAXW) : Len;
    assign w_brk_min = CW'(r_len) + CW'(2);
    assign w_mask    = ~({MAXW{1'b1}} << r_len);

    // Bit timer restarts on every state change and is held clear while idle.
    assign w_tmr_clr = (w_next != r_state) || (r_state == ST_IDLE);

    uart_bit_timer #(.OVS(OVS)) u_bit_timer (
        .Clk    (Clk),
        .Rst    (Rst),
        .i_ce   (CE_Ovs),
        .i_clr  (w_tmr_clr),
        .o_full (w_full),
        .o_half (w_half)
    );

    always_comb begin
        w_stop_done = 1'b0;
        if (r_state == ST_STOP) begin
            case (r_nstop)
                STOP_1:   w_stop_done = w_full;
                STOP_1P5: w_stop_done = w_half && (r_bitcnt == CW'(1));
                default:  w_stop_done = w_full && (r_bitcnt == CW'(1));
            endcase
        end
    end

    // Character boundary decision: CTSi and Brk only matter here.
    always_comb begin
        if (Brk)
            w_boundary = ST_BREAK;
        else if (!TF_EF && CTSi)
            w_boundary = ST_START;
        else
            w_boundary = ST_STOP_DLY;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (CE_Ovs) begin
                    if (Brk)
                        w_next = ST_BREAK;
                    else if (!TF_EF)
                        w_next = ST_START_DLY;
                end
            end
            ST_START_DLY: begin
                if (w_full) begin
                    if (TF_EF)
                        w_next = ST_IDLE;
                    else if (CTSi)
                        w_next = ST_START;
                end
            end
            ST_START:  if (w_full) w_next = ST_DATA;
            ST_DATA: begin
                if (w_full && (r_bitcnt == CW'(r_len) - CW'(1)))
                    w_next = r_paren ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_full) w_next = ST_STOP;
            ST_STOP: begin
                if (w_stop_done)
                    w_next = (r_guard != '0) ? ST_GUARD : w_boundary;
            end
            ST_GUARD: begin
                if (w_full && (r_bitcnt == CW'(r_guard) - CW'(1)))
                    w_next = w_boundary;
            end
            ST_STOP_DLY: begin
                if (w_full) begin
                    if (TF_EF)
                        w_next = ST_IDLE;
                    else if (CTSi)
                        w_next = ST_START;
                    else
                        w_next = ST_START_DLY;
                end
            end
            ST_BREAK: begin
                if (w_full && !Brk && (r_bitcnt >= w_brk_min - CW'(1)))
                    w_next = ST_BRK_MARK;
            end
            ST_BRK_MARK: if (w_full) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_load      = (w_next == ST_START) && (r_state != ST_START);
    assign w_brk_enter = (w_next == ST_BREAK) && (r_state != ST_BREAK);

    always_comb begin
        w_data_bit = 1'b1;
        for (int i = 0; i < MAXW; i++) begin
            if (r_bitcnt == CW'(i))
                w_data_bit = r_tsr[i];
        end
    end

    always_comb begin
        case (r_par)
            PAR_ODD:   w_parity = ~^(r_tsr & w_mask);
            PAR_EVEN:  w_parity = ^(r_tsr & w_mask);
            PAR_SPACE: w_parity = 1'b0;
            default:   w_parity = 1'b1;
        endcase
    end

    always_comb begin
        case (r_state)
            ST_START:  w_txd = 1'b0;
            ST_BREAK:  w_txd = 1'b0;
            ST_DATA:   w_txd = w_data_bit;
            ST_PARITY: w_txd = w_parity;
            default:   w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state  <= ST_IDLE;
            r_tsr    <= '1;
            r_len    <= 4'(MAXW);
            r_nstop  <= STOP_1;
            r_paren  <= 1'b0;
            r_par    <= PAR_ODD;
            r_guard  <= '0;
            r_bitcnt <= '0;
            r_txd    <= 1'b1;
            r_tf_re  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_txd   <= w_txd;
            r_tf_re <= w_load;
            r_done  <= w_stop_done;
            if (w_next != r_state)
                r_bitcnt <= '0;
            else if (w_full && !(r_state == ST_BREAK && r_bitcnt >= w_brk_min))
                r_bitcnt <= r_bitcnt + CW'(1);
            if (w_load) begin
                r_tsr   <= THR;
                r_len   <= w_len_eff;
                r_nstop <= NumStop;
                r_paren <= ParEn;
                r_par   <= Par;
                r_guard <= Guard;
            end else if (w_brk_enter) begin
                r_len <= w_len_eff;
            end
        end
    end

    assign TxD     = r_txd;
    assign TF_RE   = r_tf_re;
    assign TxDone  = r_done;
    assign TxIdle  = (r_state == ST_IDLE);
    assign TxStart = (r_state == ST_START);
    assign TxShift = (r_state == ST_START) || (r_state == ST_DATA) ||
                     (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign TxStop  = (r_state == ST_STOP);
    assign TxBrk   = (r_state == ST_BREAK);

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed self-checking bench for uart_tx_engine
module tb_uart_tx_engine;

    localparam int BIT = 32;

    logic       Clk;
    logic       Rst;
    logic       CE_Ovs;
    logic [3:0] Len;
    logic [1:0] NumStop;
    logic       ParEn;
    logic [1:0] Par;
    logic [7:0] Guard;
    logic       Brk;
    logic       TF_EF;
    logic [8:0] THR;
    logic       TF_RE;
    logic       CTSi;
    logic       TxD;
    logic       TxIdle;
    logic       TxStart;
    logic       TxShift;
    logic       TxStop;
    logic       TxBrk;
    logic       TxDone;

    int checks = 0;
    int failures = 0;
    int tf_re_cnt = 0;
    int done_cnt = 0;
    logic [8:0] words [0:31];
    int wr_n = 0;
    int rd_n = 0;
    logic cap_q[$];
    int exp_v[$];
    int exp_l[$];
    int s, b_re, b_dn, n;

    uart_tx_engine #(.OVS(16), .MAXW(9), .GW(8)) dut (
        .Clk(Clk), .Rst(Rst), .CE_Ovs(CE_Ovs), .Len(Len), .NumStop(NumStop),
        .ParEn(ParEn), .Par(Par), .Guard(Guard), .Brk(Brk), .TF_EF(TF_EF),
        .THR(THR), .TF_RE(TF_RE), .CTSi(CTSi), .TxD(TxD), .TxIdle(TxIdle),
        .TxStart(TxStart), .TxShift(TxShift), .TxStop(TxStop), .TxBrk(TxBrk),
        .TxDone(TxDone)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        CE_Ovs = 1'b0;
        forever begin
            @(posedge Clk);
            #1 CE_Ovs = ~CE_Ovs;
        end
    end

    initial forever begin
        @(negedge Clk);
        if (TF_RE) tf_re_cnt++;
        if (TxDone) done_cnt++;
        if (CE_Ovs) cap_q.push_back(TxD);
    end

    initial begin
        THR = '0;
        TF_EF = 1'b1;
        forever begin
            @(negedge Clk);
            if (TF_RE && rd_n < wr_n) rd_n++;
            TF_EF = (rd_n == wr_n);
            THR = (rd_n < wr_n) ? words[rd_n % 32] : 9'h000;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [8:0] w);
        words[wr_n % 32] = w;
        wr_n++;
    endtask

    task automatic ex(input int v, input int l);
        exp_v.push_back(v);
        exp_l.push_back(l);
    endtask

    task automatic wait_cycles(input int c);
        repeat (c) @(negedge Clk);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_cnt < target && k < 3000) begin
            @(negedge Clk);
            k++;
        end
        check({tag, "_done"}, done_cnt, target);
    endtask

    task automatic wait_re(input int target, input string tag);
        int k = 0;
        while (tf_re_cnt < target && k < 2000) begin
            @(negedge Clk);
            k++;
        end
        check({tag, "_re_seen"}, tf_re_cnt, target);
    endtask

    // Run-length encode the captured per-tick line and compare against exp_v/exp_l (length 0 = open-ended).
    task automatic check_line(input string tag, input int start);
        int rv[$];
        int rl[$];
        int e = cap_q.size();
        for (int i = start; i < e; i++) begin
            if (rv.size() == 0 || rv[rv.size()-1] != int'(cap_q[i])) begin
                rv.push_back(int'(cap_q[i]));
                rl.push_back(1);
            end else begin
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end
        end
        check({tag, "_runs"}, rv.size(), exp_v.size() + 1);
        if (rv.size() > 0) check({tag, "_idle"}, rv[0], 1);
        for (int i = 0; i < exp_v.size(); i++) begin
            if (i + 1 < rv.size()) begin
                check($sformatf("%s_v%0d", tag, i), rv[i+1], exp_v[i]);
                if (exp_l[i] != 0) check($sformatf("%s_l%0d", tag, i), rl[i+1], exp_l[i]);
            end
        end
        exp_v.delete();
        exp_l.delete();
    endtask

    initial begin
        Rst = 1'b1; Len = 4'd8; NumStop = 2'd0; ParEn = 1'b0; Par = 2'd0;
        Guard = 8'd0; Brk = 1'b0; CTSi = 1'b1;
        #3 Rst = 1'b0;
        wait_cycles(3);
        check("rst_txd", TxD, 1);
        check("rst_idle", TxIdle, 1);
        check("rst_tf_re", TF_RE, 0);
        check("rst_done", TxDone, 0);
        check("rst_shift", TxShift, 0);
        check("rst_start", TxStart, 0);
        check("rst_stop", TxStop, 0);
        check("rst_brk", TxBrk, 0);
        Rst = 1'b1;
        wait_cycles(4);

        // 0x55, 8N1: alternating line, 16 ticks per bit
        s = cap_q.size(); b_re = tf_re_cnt; b_dn = done_cnt;
        push(9'h055);
        wait_done(b_dn + 1, "c55");
        wait_cycles(3 * BIT);
        for (int i = 0; i < 9; i++) ex((i % 2 == 0) ? 0 : 1, 16);
        ex(1, 0);
        check_line("c55", s);
        check("c55_re", tf_re_cnt - b_re, 1);
        check("c55_dn", done_cnt - b_dn, 1);

        // 7E1.5, 0x7F twice back to back: 7 ones + parity 1 + 24-tick stop
        Len = 4'd7; ParEn = 1'b1; Par = 2'd1; NumStop = 2'd1;
        s = cap_q.size(); b_re = tf_re_cnt; b_dn = done_cnt;
        push(9'h07F); push(9'h07F);
        wait_done(b_dn + 2, "even");
        wait_cycles(3 * BIT);
        ex(0, 16); ex(1, 152); ex(0, 16); ex(1, 0);
        check_line("even", s);
        check("even_re", tf_re_cnt - b_re, 2);

        // 7O1, 0x7F: odd parity bit is 0
        Par = 2'd0; NumStop = 2'd0;
        s = cap_q.size(); b_dn = done_cnt;
        push(9'h07F);
        wait_done(b_dn + 1, "odd");
        wait_cycles(3 * BIT);
        ex(0, 16); ex(1, 112); ex(0, 16); ex(1, 0);
        check_line("odd", s);

        // 8S1, 0xFF: space parity
        Len = 4'd8; Par = 2'd2;
        s = cap_q.size(); b_dn = done_cnt;
        push(9'h0FF);
        wait_done(b_dn + 1, "space");
        wait_cycles(3 * BIT);
        ex(0, 16); ex(1, 128); ex(0, 16); ex(1, 0);
        check_line("space", s);

        // Guard=3 between two 0x00 words: 16 stop + 48 guard ticks of mark
        ParEn = 1'b0; Guard = 8'd3;
        s = cap_q.size(); b_dn = done_cnt;
        push(9'h000); push(9'h000);
        wait_done(b_dn + 2, "guard");
        wait_cycles(3 * BIT);
        ex(0, 144); ex(1, 64); ex(0, 144); ex(1, 0);
        check_line("guard", s);

        // Guard=0, two stop bits, back to back
        Guard = 8'd0; NumStop = 2'd2;
        s = cap_q.size(); b_dn = done_cnt;
        push(9'h000); push(9'h000);
        wait_done(b_dn + 2, "b2b");
        wait_cycles(3 * BIT);
        ex(0, 144); ex(1, 32); ex(0, 144); ex(1, 0);
        check_line("b2b", s);
        NumStop = 2'd0;

        // Nine data bits 0x1A5, then same with illegal Len=3 (treated as 9)
        for (int k = 0; k < 2; k++) begin
            Len = (k == 0) ? 4'd9 : 4'd3;
            s = cap_q.size(); b_dn = done_cnt;
            push(9'h1A5);
            wait_done(b_dn + 1, "len9");
            wait_cycles(3 * BIT);
            ex(0, 16); ex(1, 16); ex(0, 16); ex(1, 16); ex(0, 32); ex(1, 16); ex(0, 16); ex(1, 0);
            check_line((k == 0) ? "len9" : "len3", s);
        end
        Len = 4'd8;

        // CTSi low with data queued: parked in START_DLY, line marking
        CTSi = 1'b0;
        s = cap_q.size(); b_re = tf_re_cnt; b_dn = done_cnt;
        push(9'h0F0);
        wait_cycles(5 * BIT);
        check("cts_txd", TxD, 1);
        check("cts_idle", TxIdle, 0);
        check("cts_start", TxStart, 0);
        check("cts_re", tf_re_cnt - b_re, 0);
        CTSi = 1'b1;
        wait_done(b_dn + 1, "cts");
        wait_cycles(3 * BIT);
        ex(0, 80); ex(1, 0);
        check_line("cts", s);

        // CTSi dropped mid-character: first completes, second waits
        b_re = tf_re_cnt; b_dn = done_cnt;
        push(9'h00F); push(9'h00F);
        wait_re(b_re + 1, "ctsdrop");
        wait_cycles(2 * BIT);
        CTSi = 1'b0;
        wait_done(b_dn + 1, "ctsdrop1");
        wait_cycles(4 * BIT);
        check("ctsdrop_re", tf_re_cnt - b_re, 1);
        check("ctsdrop_txd", TxD, 1);
        CTSi = 1'b1;
        wait_done(b_dn + 2, "ctsdrop2");
        check("ctsdrop_re2", tf_re_cnt - b_re, 2);
        wait_cycles(3 * BIT);

        // Brk raised mid-character: stop completes, 10-bit break, 1-bit mark, idle
        s = cap_q.size(); b_re = tf_re_cnt; b_dn = done_cnt;
        push(9'h000);
        wait_re(b_re + 1, "brk");
        wait_cycles(2 * BIT);
        Brk = 1'b1;
        n = 0;
        while (!TxBrk && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check("brk_enter", TxBrk, 1);
        check("brk_dn", done_cnt - b_dn, 1);
        wait_cycles(3 * BIT);
        Brk = 1'b0;
        n = 0;
        while (!TxIdle && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        check("brk_idle", TxIdle, 1);
        wait_cycles(2 * BIT);
        ex(0, 144); ex(1, 16); ex(0, 160); ex(1, 0);
        check_line("brk", s);

        // Reset mid-DATA: TxD marks at once, no further FIFO read
        b_re = tf_re_cnt; b_dn = done_cnt;
        push(9'h000); push(9'h0AA);
        wait_re(b_re + 1, "rst");
        wait_cycles(3 * BIT);
        CTSi = 1'b0;
        #2 Rst = 1'b0;
        #1;
        check("rstmid_txd", TxD, 1);
        check("rstmid_tf_re", TF_RE, 0);
        check("rstmid_idle", TxIdle, 1);
        check("rstmid_shift", TxShift, 0);
        wait_cycles(2);
        Rst = 1'b1;
        wait_cycles(4 * BIT);
        check("rstmid_re", tf_re_cnt - b_re, 1);
        check("rstmid_dn", done_cnt - b_dn, 0);
        check("rstmid_wait", TxIdle, 0);
        s = cap_q.size();
        CTSi = 1'b1;
        wait_done(b_dn + 1, "rstmid");
        wait_cycles(3 * BIT);
        check("rstmid_re2", tf_re_cnt - b_re, 2);
        ex(0, 32); ex(1, 16); ex(0, 16); ex(1, 16); ex(0, 16); ex(1, 16); ex(0, 16); ex(1, 0);
        check_line("rstmid", s);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
